// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, reset vector, opcode/funct
// constants used by fetch and decode, and the fetch FSM state encoding.
package cpu_pkg;

    localparam int          ADDR_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_SYSCALL = 6'b001100;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory-side, decoder-side and control signals.
// Handshakes: a transfer happens on a rising edge where the producer's
// valid/req and the consumer's ready are both high; the producer holds its
// payload stable until that edge, except when a redirect abandons it.
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int AW = ADDR_W
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic [31:0]   imem_rdata;

    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_word;
    logic [5:0]    opcode;
    logic [5:0]    func;
    logic [AW-1:0] inst_pc;
    logic [AW-1:0] inst_pc_plus4;

    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic          halted;
    logic          misalign_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output inst_valid, inst_word, opcode, func, inst_pc, inst_pc_plus4,
        input  inst_ready,
        input  redirect_valid, redirect_pc, halt,
        output halted, misalign_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  inst_valid, inst_word, opcode, func, inst_pc, inst_pc_plus4,
        output inst_ready,
        output redirect_valid, redirect_pc, halt,
        input  halted, misalign_err
    );

endinterface

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch: request a word, hold it for the decoder,
// advance PC on acceptance. Redirects squash whatever is in flight.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                AW       = ADDR_W,
    parameter logic [AW-1:0]     RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output fetch_state_t state_dbg
);

    fetch_state_t  state, state_d;
    logic [AW-1:0] pc, pc_d;
    logic [31:0]   inst_word_q;
    logic [AW-1:0] inst_pc_q;
    logic          misalign_q;

    logic take_redirect;
    logic fetch_done;
    logic accept;

    // Redirect beats everything except halt; a halted core ignores it.
    assign take_redirect = bus.redirect_valid && (state != S_HALT);
    assign fetch_done    = (state == S_REQ)  && bus.imem_ready && !take_redirect;
    assign accept        = (state == S_HOLD) && bus.inst_ready && !take_redirect;

    // Next-state and next-PC selection.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        if (take_redirect) begin
            state_d = S_REQ;
            pc_d    = {bus.redirect_pc[AW-1:2], 2'b00};
        end else if (fetch_done) begin
            state_d = S_HOLD;
        end else if (accept) begin
            if (bus.halt) begin
                state_d = S_HALT;
            end else begin
                state_d = S_REQ;
                pc_d    = inst_pc_q + AW'(4);
            end
        end
    end

    // State, PC, instruction register and sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            inst_word_q <= '0;
            inst_pc_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (fetch_done) begin
                inst_word_q <= bus.imem_rdata;
                inst_pc_q   <= pc;
            end
            if (take_redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // Outputs: request is suppressed while reset is asserted.
    assign bus.imem_req      = (state == S_REQ) && rst_n;
    assign bus.imem_addr     = pc;
    assign bus.inst_valid    = (state == S_HOLD);
    assign bus.inst_word     = inst_word_q;
    assign bus.opcode        = inst_word_q[31:26];
    assign bus.func          = inst_word_q[5:0];
    assign bus.inst_pc       = inst_pc_q;
    assign bus.inst_pc_plus4 = inst_pc_q + AW'(4);
    assign bus.halted        = (state == S_HALT);
    assign bus.misalign_err  = misalign_q;
    assign state_dbg         = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of the program counter.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.AW(32)) bus ();
    fetch_unit_if #(.AW(32)) bus2 ();
    fetch_state_t st1, st2;

    fetch_unit #(.AW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master), .state_dbg(st1)
    );
    fetch_unit #(.AW(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.master), .state_dbg(st2)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    // one active edge, then sample away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic idle_inputs();
        bus.imem_ready = 0; bus.imem_rdata = '0; bus.inst_ready = 0;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.halt = 0;
        bus2.imem_ready = 0; bus2.imem_rdata = '0; bus2.inst_ready = 0;
        bus2.redirect_valid = 0; bus2.redirect_pc = '0; bus2.halt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        step(); step();
        total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.imem_req); else pass_cnt++;
        total_cnt++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.inst_valid); else pass_cnt++;
        total_cnt++; if (bus.inst_word !== 32'h0) $display("FAIL reset_word got %h want 0", bus.inst_word); else pass_cnt++;
        total_cnt++; if (bus.inst_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", bus.inst_pc); else pass_cnt++;
        total_cnt++; if (bus.halted !== 1'b0 || bus.misalign_err !== 1'b0)
            $display("FAIL reset_flags got %b%b want 00", bus.halted, bus.misalign_err); else pass_cnt++;
        rst_n = 1;
        #1;
        total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
            $display("FAIL first_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        bus.imem_ready = 1; bus.imem_rdata = 32'h2008_0005;
        step();
        bus.imem_ready = 0; bus.imem_rdata = '0;
        total_cnt++; if (bus.inst_valid !== 1'b1) $display("FAIL zw_valid got %b want 1", bus.inst_valid); else pass_cnt++;
        total_cnt++; if (bus.opcode !== 6'b001000 || bus.func !== 6'b000101)
            $display("FAIL zw_slices got %b/%b want 001000/000101", bus.opcode, bus.func); else pass_cnt++;
        total_cnt++; if (bus.inst_pc !== 32'h0 || bus.inst_pc_plus4 !== 32'h4)
            $display("FAIL zw_pc got %h/%h want 0/4", bus.inst_pc, bus.inst_pc_plus4); else pass_cnt++;
        total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL zw_req_low got %b want 0", bus.imem_req); else pass_cnt++;
        bus.inst_ready = 1;
        step();
        bus.inst_ready = 0;
        total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4)
            $display("FAIL zw_next got %b/%h want 1/4", bus.imem_req, bus.imem_addr); else pass_cnt++;
    endtask

    task automatic test_delayed();
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.inst_valid !== 1'b0)
                $display("FAIL delay_hold%0d got %b/%h/%b want 1/4/0", i, bus.imem_req, bus.imem_addr, bus.inst_valid);
            else pass_cnt++;
            if (i < 3) step();
        end
        bus.imem_ready = 1; bus.imem_rdata = 32'h8C22_0010;
        step();
        bus.imem_ready = 0; bus.imem_rdata = '0;
        total_cnt++; if (bus.inst_valid !== 1'b1 || bus.inst_word !== 32'h8C22_0010 || bus.inst_pc !== 32'h4)
            $display("FAIL delay_data got %b/%h/%h want 1/8c220010/4", bus.inst_valid, bus.inst_word, bus.inst_pc);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++; if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0 ||
                             bus.inst_word !== 32'h8C22_0010 || bus.inst_pc !== 32'h4)
                $display("FAIL bp_stable%0d got %b/%b/%h/%h want 1/0/8c220010/4", i,
                         bus.inst_valid, bus.imem_req, bus.inst_word, bus.inst_pc);
            else pass_cnt++;
        end
        bus.inst_ready = 1;
        step();
        bus.inst_ready = 0;
        total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.inst_valid !== 1'b0)
            $display("FAIL bp_next got %b/%h/%b want 1/8/0", bus.imem_req, bus.imem_addr, bus.inst_valid);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        bus.imem_ready = 1; bus.imem_rdata = 32'hDEAD_BEEF;
        bus.redirect_valid = 1; bus.redirect_pc = 32'h40;
        step();
        idle_inputs();
        total_cnt++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h40 || bus.misalign_err !== 1'b0)
            $display("FAIL redir_discard got %b/%h/%b want 0/40/0", bus.inst_valid, bus.imem_addr, bus.misalign_err);
        else pass_cnt++;
        bus.redirect_valid = 1; bus.redirect_pc = 32'h43;
        step();
        idle_inputs();
        total_cnt++; if (bus.imem_addr !== 32'h40 || bus.misalign_err !== 1'b1 || bus.imem_req !== 1'b1)
            $display("FAIL redir_misalign got %h/%b/%b want 40/1/1", bus.imem_addr, bus.misalign_err, bus.imem_req);
        else pass_cnt++;
        // squash a held instruction even while the decoder accepts it
        bus.imem_ready = 1; bus.imem_rdata = 32'h1234_5678;
        step();
        idle_inputs();
        bus.inst_ready = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h80;
        step();
        idle_inputs();
        total_cnt++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h80 || bus.misalign_err !== 1'b1)
            $display("FAIL redir_squash got %b/%h/%b want 0/80/1", bus.inst_valid, bus.imem_addr, bus.misalign_err);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        bus.imem_ready = 1; bus.imem_rdata = 32'h0000_000C;
        step();
        idle_inputs();
        total_cnt++; if (bus.func !== FUNCT_SYSCALL || bus.opcode !== OP_RTYPE || bus.inst_pc !== 32'h80)
            $display("FAIL halt_word got %b/%b/%h want 001100/000000/80", bus.func, bus.opcode, bus.inst_pc);
        else pass_cnt++;
        bus.inst_ready = 1; bus.halt = 1;
        step();
        idle_inputs();
        total_cnt++; if (bus.halted !== 1'b1 || bus.inst_valid !== 1'b0)
            $display("FAIL halt_enter got %b/%b want 1/0", bus.halted, bus.inst_valid); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            bus.redirect_valid = 1'($urandom_range(0, 1));
            bus.redirect_pc    = $urandom;
            bus.imem_ready     = 1'($urandom_range(0, 1));
            bus.imem_rdata     = $urandom;
            bus.inst_ready     = 1'($urandom_range(0, 1));
            step();
            total_cnt++; if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1 || bus.inst_valid !== 1'b0)
                $display("FAIL halt_stay%0d got %b/%b/%b want 0/1/0", i, bus.imem_req, bus.halted, bus.inst_valid);
            else pass_cnt++;
        end
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        total_cnt++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1 || bus.halted !== 1'b0 || bus.misalign_err !== 1'b0)
            $display("FAIL halt_reset got %h/%b/%b/%b want 0/1/0/0", bus.imem_addr, bus.imem_req, bus.halted, bus.misalign_err);
        else pass_cnt++;
    endtask

    // Model: the expected PC advances by 4 on each delivered instruction and
    // jumps to the aligned target on a redirect; memory content is a pure
    // function of the address.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        exp_mis;
        int          wait_cnt;
        int          deliveries;
        logic        was_valid;
        logic [31:0] tgt;
        exp_pc = 32'h0; exp_mis = 1'b0; wait_cnt = 0; deliveries = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (bus.imem_req) begin
                total_cnt++; if (bus.imem_addr !== exp_pc)
                    $display("FAIL rnd_addr cyc%0d got %h want %h", cyc, bus.imem_addr, exp_pc);
                else pass_cnt++;
            end
            if (bus.inst_valid) begin
                total_cnt++; if (bus.inst_pc !== exp_pc || bus.inst_word !== mem_word(exp_pc) ||
                                 bus.inst_pc_plus4 !== exp_pc + 32'd4 ||
                                 bus.opcode !== mem_word(exp_pc) >> 26 ||
                                 bus.func !== 6'(mem_word(exp_pc)))
                    $display("FAIL rnd_inst cyc%0d got pc %h word %h p4 %h want pc %h word %h", cyc,
                             bus.inst_pc, bus.inst_word, bus.inst_pc_plus4, exp_pc, mem_word(exp_pc));
                else pass_cnt++;
            end
            // drive inputs for the next edge
            if (bus.imem_req) begin
                bus.imem_ready = (wait_cnt == 0);
                bus.imem_rdata = (wait_cnt == 0) ? mem_word(bus.imem_addr) : $urandom;
                wait_cnt = (wait_cnt == 0) ? $urandom_range(0, 3) : wait_cnt - 1;
            end else begin
                bus.imem_ready = 1'($urandom_range(0, 1));
                bus.imem_rdata = $urandom;
            end
            bus.inst_ready     = ($urandom_range(0, 2) != 0);
            bus.redirect_valid = ($urandom_range(0, 11) == 0);
            tgt = {16'h0, 16'($urandom)};
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            bus.redirect_pc = tgt;
            was_valid = bus.inst_valid;
            step();
            if (bus.redirect_valid) begin
                exp_pc = tgt & 32'hFFFF_FFFC;
                if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
            end else if (was_valid && bus.inst_ready) begin
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
        end
        idle_inputs();
        total_cnt++; if (bus.misalign_err !== exp_mis || bus.halted !== 1'b0)
            $display("FAIL rnd_flags got %b/%b want %b/0", bus.misalign_err, bus.halted, exp_mis);
        else pass_cnt++;
        total_cnt++; if (deliveries < 40)
            $display("FAIL rnd_progress got %0d deliveries want >=40", deliveries);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        total_cnt++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_first got %b/%h want 1/fffffffc", bus2.imem_req, bus2.imem_addr); else pass_cnt++;
        bus2.imem_ready = 1; bus2.imem_rdata = 32'h0800_0010;
        step();
        idle_inputs();
        total_cnt++; if (bus2.inst_pc !== 32'hFFFF_FFFC || bus2.inst_pc_plus4 !== 32'h0)
            $display("FAIL wrap_pc got %h/%h want fffffffc/0", bus2.inst_pc, bus2.inst_pc_plus4); else pass_cnt++;
        bus2.inst_ready = 1;
        step();
        idle_inputs();
        total_cnt++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'h0)
            $display("FAIL wrap_next got %b/%h want 1/0", bus2.imem_req, bus2.imem_addr); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed();
        test_backpressure();
        test_redirect();
        test_halt();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
